pipeline_control_unit: RTL and testbench
========================================

Name: pipeline_control_unit

Overview:
Central sequencer for the 5-stage MIPS pipeline. Generates the global stage enable, the hazard stall for instruction_decode, PC and IF/ID write enables, and the IF/ID flush on taken jumps. A run-mode FSM provides continuous run, single-step (debug unit) and halt draining. Sits beside the pipeline; the debug/UART unit drives it.

Parameters:
DRAIN_CYCLES, 4, cycles the pipeline keeps running after HALT is decoded so that EX/MEM/WB retire.
NB_REG_ADDR, 5, register address width.

Ports:
i_clk  in  1  clock
i_reset  in  1  reset; synchronous, active-high
i_start  in  1  one-cycle pulse; leave IDLE
i_step_mode  in  1  1 single-step, 0 continuous; sampled with i_start
i_step  in  1  one-cycle pulse; advance one cycle in STEP_WAIT
i_halt  in  1  HALT decoded in ID (comb)
i_jump  in  1  taken branch/jump resolved in ID (comb)
i_id_opcode  in  6  opcode of instruction in ID
i_id_funct  in  6  funct of instruction in ID
i_id_rs  in  5  rs in ID
i_id_rt  in  5  rt in ID
i_ex_mem_read  in  1  ID/EX load flag
i_ex_wb_write  in  1  ID/EX register write flag
i_ex_rd_dst  in  5  destination register of the instruction in EX (after reg_dst mux)
i_mem_mem_read  in  1  EX/MEM load flag
i_mem_rd_dst  in  5  destination register of the instruction in MEM
o_enable  out  1  global stage enable (all pipeline registers)
o_stall  out  1  to ID: bubble into ID/EX
o_pc_write  out  1  PC update enable
o_if_id_write  out  1  IF/ID update enable
o_if_id_flush  out  1  load NOP into IF/ID
o_done  out  1  high in HALTED
o_state  out  3  current FSM state code

Behaviour:
- Reset (synchronous): state=IDLE; every output 0; drain counter 0.
- States: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, HALTED=5.
- IDLE: on i_start -> STEP_WAIT if i_step_mode, else RUN. o_enable=0.
- RUN: o_enable=1. When i_halt && !o_stall -> DRAIN, counter loaded with DRAIN_CYCLES-1.
- STEP_WAIT: o_enable=0. On i_step -> STEP_EXEC.
- STEP_EXEC: o_enable=1 for exactly one cycle, then STEP_WAIT; if i_halt && !o_stall that cycle -> DRAIN.
- DRAIN: o_enable=1; counter decrements each cycle; at 0 -> HALTED. o_pc_write=0 and o_if_id_write=0 throughout DRAIN so the fetch side stays frozen on HALT.
- HALTED: o_enable=0, o_done=1. Only i_reset exits. i_start is ignored.
- Hazard detection is combinational, gated by o_enable (all hazard outputs are 0 when o_enable=0). Register 0 never causes a hazard.
  - Load-use: i_ex_mem_read && i_ex_rd_dst in {i_id_rs, i_id_rt}.
  - Branch/JR operand: ID opcode is BEQ(000100) or BNE(000101), or R-type with funct JR(001000) or JALR(001001); and either
    - i_ex_wb_write && i_ex_rd_dst matches a used source, or
    - i_mem_mem_read && i_mem_rd_dst matches a used source.
  - Sources used: BEQ/BNE use rs and rt; JR/JALR use rs only.
  - On hazard: o_stall=1, o_pc_write=0, o_if_id_write=0.
- Flush: o_if_id_flush = o_enable && i_jump && !o_stall. A stall has priority over a jump, since the jump is evaluated on stale operands.
- Otherwise, with o_enable=1 outside DRAIN: o_pc_write=1 and o_if_id_write=1.
- i_halt while stalled: no transition; re-evaluated once the stall clears.
- Stalls persist across single steps; each step is one clock.

Optional Feature:
- Macro PIPE_CYCLE_COUNTER_EN.
- Defined: adds output o_cycle_count (32 bits).
  - Reset to 0; increments each cycle o_enable=1, including DRAIN.
  - Wraps at 2^32-1 -> 0.
  - Frozen in HALTED.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package pipeline_pkg holds:
  - opcode/funct constants (BEQ, BNE, JR, JALR, R-type);
  - FSM state encodings;
  - the DRAIN_CYCLES default.
- One sub-module is natural: hazard_detection_unit (purely combinational compare logic). The FSM and enables stay in pipeline_control_unit.

Test Plan:
- Reset, i_start with step_mode=0; HALT decoded at cycle 10 -> DRAIN for 4 cycles with o_pc_write=0; o_done=1 at cycle 15; i_start afterwards ignored.
- Step mode, three i_step pulses spaced 5 cycles apart -> o_enable high exactly 3 single cycles; o_state alternates 2/3.
- Load-use: EX mem_read=1, rd=8; ID rs=8 -> o_stall=1, pc/if_id write=0 for 1 cycle. Same case with rd=0 -> no stall.
- BEQ in ID, rs=5; EX writes r5 -> stall. Next cycle MEM is a load to r5 -> stall continues. Then released; i_jump=1 -> o_if_id_flush=1 for one cycle.
- i_jump=1 with a simultaneous hazard -> o_stall=1, o_if_id_flush=0.
- Reset asserted mid-DRAIN -> next cycle state=IDLE and all outputs 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS pipeline control slice: opcodes, functs, FSM states.
package pipeline_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] FUNCT_JR   = 6'b001000;
   localparam logic [5:0] FUNCT_JALR = 6'b001001;

   localparam int DRAIN_CYCLES_DEFAULT = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_STEP_WAIT = 3'd2,
      ST_STEP_EXEC = 3'd3,
      ST_DRAIN     = 3'd4,
      ST_HALTED    = 3'd5
   } state_t;

endpackage

// File: rtl/hazard_detection_unit.sv
// Combinational load-use and branch/JR operand hazard detection for the ID stage.
module hazard_detection_unit
   import pipeline_pkg::*;
#(
   parameter int NB_REG_ADDR = 5
)
(
   input  logic [5:0]             i_id_opcode,
   input  logic [5:0]             i_id_funct,
   input  logic [NB_REG_ADDR-1:0] i_id_rs,
   input  logic [NB_REG_ADDR-1:0] i_id_rt,
   input  logic                   i_ex_mem_read,
   input  logic                   i_ex_wb_write,
   input  logic [NB_REG_ADDR-1:0] i_ex_rd_dst,
   input  logic                   i_mem_mem_read,
   input  logic [NB_REG_ADDR-1:0] i_mem_rd_dst,
   output logic                   o_hazard
);

   logic is_branch;
   logic is_jump_reg;
   logic load_use;
   logic ex_dep;
   logic mem_dep;

   // Branches compare rs and rt in ID; JR/JALR only read rs.
   function automatic logic reads_reg(input logic [NB_REG_ADDR-1:0] dst,
                                      input logic [NB_REG_ADDR-1:0] rs,
                                      input logic [NB_REG_ADDR-1:0] rt,
                                      input logic                   use_rt);
      return (dst != '0) && ((dst == rs) || (use_rt && (dst == rt)));
   endfunction

   assign is_branch   = (i_id_opcode == OP_BEQ) || (i_id_opcode == OP_BNE);
   assign is_jump_reg = (i_id_opcode == OP_RTYPE) &&
                        ((i_id_funct == FUNCT_JR) || (i_id_funct == FUNCT_JALR));

   assign load_use = i_ex_mem_read && reads_reg(i_ex_rd_dst, i_id_rs, i_id_rt, 1'b1);
   assign ex_dep   = i_ex_wb_write && reads_reg(i_ex_rd_dst, i_id_rs, i_id_rt, is_branch);
   assign mem_dep  = i_mem_mem_read && reads_reg(i_mem_rd_dst, i_id_rs, i_id_rt, is_branch);

   assign o_hazard = load_use || ((is_branch || is_jump_reg) && (ex_dep || mem_dep));

endmodule

// File: rtl/pipeline_control_unit.sv
// Run-mode FSM, stage enables and hazard stall/flush for the 5-stage MIPS pipeline.
// Optional cycle counter output enabled by defining PIPE_CYCLE_COUNTER_EN.
module pipeline_control_unit
   import pipeline_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
   parameter int NB_REG_ADDR  = 5
)
(
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic                   i_step_mode,
   input  logic                   i_step,
   input  logic                   i_halt,
   input  logic                   i_jump,
   input  logic [5:0]             i_id_opcode,
   input  logic [5:0]             i_id_funct,
   input  logic [NB_REG_ADDR-1:0] i_id_rs,
   input  logic [NB_REG_ADDR-1:0] i_id_rt,
   input  logic                   i_ex_mem_read,
   input  logic                   i_ex_wb_write,
   input  logic [NB_REG_ADDR-1:0] i_ex_rd_dst,
   input  logic                   i_mem_mem_read,
   input  logic [NB_REG_ADDR-1:0] i_mem_rd_dst,
   output logic                   o_enable,
   output logic                   o_stall,
   output logic                   o_pc_write,
   output logic                   o_if_id_write,
   output logic                   o_if_id_flush,
   output logic                   o_done,
   output logic [2:0]             o_state
`ifdef PIPE_CYCLE_COUNTER_EN
   ,
   output logic [31:0]            o_cycle_count
`endif
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_t             state, state_next;
   logic [CNT_W-1:0]   drain_cnt, drain_cnt_next;
   logic               hazard;

   hazard_detection_unit #(.NB_REG_ADDR(NB_REG_ADDR)) u_hazard (
      .i_id_opcode    (i_id_opcode),
      .i_id_funct     (i_id_funct),
      .i_id_rs        (i_id_rs),
      .i_id_rt        (i_id_rt),
      .i_ex_mem_read  (i_ex_mem_read),
      .i_ex_wb_write  (i_ex_wb_write),
      .i_ex_rd_dst    (i_ex_rd_dst),
      .i_mem_mem_read (i_mem_mem_read),
      .i_mem_rd_dst   (i_mem_rd_dst),
      .o_hazard       (hazard)
   );

   // Enable depends on state alone so the stall it gates cannot loop back into the FSM.
   assign o_enable      = (state == ST_RUN) || (state == ST_STEP_EXEC) || (state == ST_DRAIN);
   assign o_stall       = o_enable && hazard;
   assign o_pc_write    = o_enable && !o_stall && (state != ST_DRAIN);
   assign o_if_id_write = o_pc_write;
   assign o_if_id_flush = o_enable && i_jump && !o_stall;
   assign o_done        = (state == ST_HALTED);
   assign o_state       = state;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
   always_comb begin
      state_next     = state;
      drain_cnt_next = drain_cnt;
      case (state)
         ST_IDLE:
            if (i_start) state_next = i_step_mode ? ST_STEP_WAIT : ST_RUN;
         ST_RUN:
            if (i_halt && !o_stall) begin
               state_next     = ST_DRAIN;
               drain_cnt_next = CNT_W'(DRAIN_CYCLES - 1);
            end
         ST_STEP_WAIT:
            if (i_step) state_next = ST_STEP_EXEC;
         ST_STEP_EXEC:
            if (i_halt && !o_stall) begin
               state_next     = ST_DRAIN;
               drain_cnt_next = CNT_W'(DRAIN_CYCLES - 1);
            end else begin
               state_next = ST_STEP_WAIT;
            end
         ST_DRAIN:
            if (drain_cnt == '0) state_next = ST_HALTED;
            else                 drain_cnt_next = drain_cnt - 1'b1;
         ST_HALTED:
            state_next = ST_HALTED;
         default:
            state_next = ST_IDLE;
      endcase
   end

`ifdef PIPE_CYCLE_COUNTER_EN
   always_ff @(posedge i_clk) begin
      if (i_reset)       o_cycle_count <= '0;
      else if (o_enable) o_cycle_count <= o_cycle_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: directed test-plan scenarios plus random stimulus
// against a behavioural model. Define PIPE_CYCLE_COUNTER_EN to also check o_cycle_count.
module tb_pipeline_control_unit;

   localparam int DRAIN = 4;

   logic        i_clk;
   logic        i_reset, i_start, i_step_mode, i_step, i_halt, i_jump;
   logic [5:0]  i_id_opcode, i_id_funct;
   logic [4:0]  i_id_rs, i_id_rt, i_ex_rd_dst, i_mem_rd_dst;
   logic        i_ex_mem_read, i_ex_wb_write, i_mem_mem_read;
   logic        o_enable, o_stall, o_pc_write, o_if_id_write, o_if_id_flush, o_done;
   logic [2:0]  o_state;
`ifdef PIPE_CYCLE_COUNTER_EN
   logic [31:0] o_cycle_count;
`endif

   int errors = 0;
   int checks = 0;

   // Behavioural model: run-mode flags and remaining drain cycles.
   bit          started, step_mode_m, step_active, halted_m;
   int          drain_left;
   logic [31:0] cyc_ref;

   pipeline_control_unit #(.DRAIN_CYCLES(DRAIN), .NB_REG_ADDR(5)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .i_step_mode    (i_step_mode),
      .i_step         (i_step),
      .i_halt         (i_halt),
      .i_jump         (i_jump),
      .i_id_opcode    (i_id_opcode),
      .i_id_funct     (i_id_funct),
      .i_id_rs        (i_id_rs),
      .i_id_rt        (i_id_rt),
      .i_ex_mem_read  (i_ex_mem_read),
      .i_ex_wb_write  (i_ex_wb_write),
      .i_ex_rd_dst    (i_ex_rd_dst),
      .i_mem_mem_read (i_mem_mem_read),
      .i_mem_rd_dst   (i_mem_rd_dst),
      .o_enable       (o_enable),
      .o_stall        (o_stall),
      .o_pc_write     (o_pc_write),
      .o_if_id_write  (o_if_id_write),
      .o_if_id_flush  (o_if_id_flush),
      .o_done         (o_done),
      .o_state        (o_state)
`ifdef PIPE_CYCLE_COUNTER_EN
      ,
      .o_cycle_count  (o_cycle_count)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_hazard();
      logic [4:0] srcs[$];
      bit         is_branch, is_jr, h;
      is_branch = (i_id_opcode == 6'd4) || (i_id_opcode == 6'd5);
      is_jr     = (i_id_opcode == 6'd0) && ((i_id_funct == 6'd8) || (i_id_funct == 6'd9));
      h = 1'b0;
      if (i_ex_mem_read && i_ex_rd_dst != 0 && (i_ex_rd_dst == i_id_rs || i_ex_rd_dst == i_id_rt))
         h = 1'b1;
      if (is_branch)  srcs = '{i_id_rs, i_id_rt};
      else if (is_jr) srcs = '{i_id_rs};
      foreach (srcs[k]) begin
         if (srcs[k] != 0) begin
            if (i_ex_wb_write && i_ex_rd_dst == srcs[k])   h = 1'b1;
            if (i_mem_mem_read && i_mem_rd_dst == srcs[k]) h = 1'b1;
         end
      end
      return h;
   endfunction

   function automatic bit ref_enable();
      return !halted_m && (drain_left > 0 || (started && (!step_mode_m || step_active)));
   endfunction

   function automatic int ref_state();
      if (halted_m)        return 5;
      if (drain_left > 0)  return 4;
      if (!started)        return 0;
      if (!step_mode_m)    return 1;
      return step_active ? 3 : 2;
   endfunction

   task automatic step_model();
      bit en, st;
      en = ref_enable();
      st = en && ref_hazard();
      if (i_reset) begin
         started = 0; step_mode_m = 0; step_active = 0; halted_m = 0; drain_left = 0;
         cyc_ref = 0;
      end else begin
         if (en) cyc_ref = cyc_ref + 1;
         if (halted_m) begin
         end else if (drain_left > 0) begin
            if (drain_left == 1) halted_m = 1;
            drain_left--;
         end else if (!started) begin
            if (i_start) begin
               started = 1; step_mode_m = i_step_mode; step_active = 0;
            end
         end else if (!step_mode_m) begin
            if (i_halt && !st) drain_left = DRAIN;
         end else if (step_active) begin
            step_active = 0;
            if (i_halt && !st) drain_left = DRAIN;
         end else if (i_step) begin
            step_active = 1;
         end
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      bit en, st;
      #1;
      en = ref_enable();
      st = en && ref_hazard();
      check("state",    o_state,       ref_state());
      check("enable",   o_enable,      en);
      check("stall",    o_stall,       st);
      check("pc_write", o_pc_write,    en && drain_left == 0 && !st);
      check("if_id_wr", o_if_id_write, en && drain_left == 0 && !st);
      check("flush",    o_if_id_flush, en && i_jump && !st);
      check("done",     o_done,        halted_m);
`ifdef PIPE_CYCLE_COUNTER_EN
      check("cycles",   o_cycle_count, cyc_ref);
`endif
      @(posedge i_clk);
      step_model();
      @(negedge i_clk);
   endtask

   task automatic clear_inputs();
      i_reset = 0; i_start = 0; i_step_mode = 0; i_step = 0; i_halt = 0; i_jump = 0;
      i_id_opcode = 6'h20; i_id_funct = 0; i_id_rs = 0; i_id_rt = 0;
      i_ex_mem_read = 0; i_ex_wb_write = 0; i_ex_rd_dst = 0;
      i_mem_mem_read = 0; i_mem_rd_dst = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      i_reset = 1;
      tick();
      i_reset = 0;
   endtask

   task automatic start(input bit step_mode);
      i_start = 1; i_step_mode = step_mode;
      tick();
      i_start = 0; i_step_mode = 0;
   endtask

   logic [4:0] pool [4];
   logic [5:0] ops  [5];
   logic [5:0] fns  [3];

   initial begin
      pool = '{5'd0, 5'd5, 5'd8, 5'd9};
      ops  = '{6'd0, 6'd4, 6'd5, 6'd35, 6'd8};
      fns  = '{6'd8, 6'd9, 6'd32};
      started = 0; step_mode_m = 0; step_active = 0; halted_m = 0; drain_left = 0; cyc_ref = 0;
      clear_inputs();
      i_reset = 1;
      @(negedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 0;
      #1;
      check("rst_state", o_state, 3'd0);
      check("rst_enable", o_enable, 1'b0);
      @(negedge i_clk);

      // Continuous run, HALT, drain, halted; later start ignored.
      start(1'b0);
      repeat (9) tick();
      i_halt = 1; tick(); i_halt = 0;
      repeat (DRAIN + 2) tick();
      start(1'b0);
      #1 check("halted_start_ignored", o_state, 3'd5);
      @(negedge i_clk);

      // Single-step mode with three spaced steps.
      do_reset();
      start(1'b1);
      repeat (3) begin
         repeat (4) tick();
         i_step = 1; tick(); i_step = 0;
         tick();
      end

      // Load-use with r8, then with r0.
      do_reset();
      start(1'b0);
      i_ex_mem_read = 1; i_ex_rd_dst = 8; i_id_rs = 8; tick();
      i_ex_rd_dst = 0; i_id_rs = 0; tick();
      clear_inputs();

      // BEQ on r5: EX write, then MEM load, then release with jump.
      i_id_opcode = 6'd4; i_id_rs = 5; i_id_rt = 9;
      i_ex_wb_write = 1; i_ex_rd_dst = 5; tick();
      i_ex_wb_write = 0; i_ex_rd_dst = 0; i_mem_mem_read = 1; i_mem_rd_dst = 5; tick();
      i_mem_mem_read = 0; i_mem_rd_dst = 0; i_jump = 1;
      #1 check("beq_flush", o_if_id_flush, 1'b1);
      @(negedge i_clk);
      tick();
      // Jump together with a hazard: stall wins.
      i_ex_wb_write = 1; i_ex_rd_dst = 5; i_halt = 1;
      #1 check("jump_hazard_flush", o_if_id_flush, 1'b0);
      @(negedge i_clk);
      tick();
      clear_inputs();

      // Reset in the middle of DRAIN.
      i_halt = 1; tick(); i_halt = 0;
      tick(); tick();
      i_reset = 1; tick(); i_reset = 0;
      #1 check("drain_reset_state", o_state, 3'd0);
      @(negedge i_clk);

      // Random stimulus.
      for (int n = 0; n < 3000; n++) begin
         i_reset        = ($urandom_range(199) == 0) || (halted_m && $urandom_range(7) == 0);
         i_start        = ($urandom_range(7) == 0);
         i_step_mode    = $urandom_range(1);
         i_step         = ($urandom_range(3) == 0);
         i_halt         = ($urandom_range(15) == 0);
         i_jump         = ($urandom_range(2) == 0);
         i_id_opcode    = ops[$urandom_range(4)];
         i_id_funct     = fns[$urandom_range(2)];
         i_id_rs        = pool[$urandom_range(3)];
         i_id_rt        = pool[$urandom_range(3)];
         i_ex_mem_read  = ($urandom_range(3) == 0);
         i_ex_wb_write  = $urandom_range(1);
         i_ex_rd_dst    = pool[$urandom_range(3)];
         i_mem_mem_read = ($urandom_range(3) == 0);
         i_mem_rd_dst   = pool[$urandom_range(3)];
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
